// File: rtl/apb3_master_bridge_pkg.sv
// Shared APB3 definitions: bridge FSM states and default bus widths
// common to the bridge and the APB3 peripheral routers.
package apb3_pkg;

  localparam int unsigned APB_ADDR_W = 16;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb3_state_e;

endpackage

// File: rtl/apb3_master_bridge_if.sv
// Command/response stream plus APB3 bus signals of the master bridge.
// "master" is the bridge's view; "slave" is the fabric/peripheral side.
interface apb3_master_bridge_if import apb3_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_W,
  parameter int unsigned DATA_WIDTH = APB_DATA_W
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic                  rsp_timeout;

  logic [ADDR_WIDTH-1:0] io_apb_PADDR;
  logic                  io_apb_PSEL;
  logic                  io_apb_PENABLE;
  logic                  io_apb_PWRITE;
  logic [DATA_WIDTH-1:0] io_apb_PWDATA;
  logic                  io_apb_PREADY;
  logic [DATA_WIDTH-1:0] io_apb_PRDATA;
  logic                  io_apb_PSLVERROR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  io_apb_PREADY, io_apb_PRDATA, io_apb_PSLVERROR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    output io_apb_PADDR, io_apb_PSEL, io_apb_PENABLE, io_apb_PWRITE, io_apb_PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output io_apb_PREADY, io_apb_PRDATA, io_apb_PSLVERROR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    input  io_apb_PADDR, io_apb_PSEL, io_apb_PENABLE, io_apb_PWRITE, io_apb_PWDATA
  );

endinterface

// File: rtl/apb3_timeout_cnt.sv
// Saturating ACCESS-phase wait counter; hit_o flags the last allowed
// wait cycle (count == TIMEOUT-1). TIMEOUT == 0 never hits.
module apb3_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HIT_VAL = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (TIMEOUT != 0) && (cnt_q == HIT_VAL);

endmodule

// File: rtl/apb3_master_bridge.sv
// Single-outstanding APB3 initiator: valid/ready command in, SETUP/ACCESS
// transfer with ACCESS timeout, valid/ready response out. All outputs registered.
module apb3_master_bridge import apb3_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_W,
  parameter int unsigned DATA_WIDTH = APB_DATA_W,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                io_apb_PCLK,
  input  logic                io_apb_PRESETn,
  apb3_master_bridge_if.master bus
);

  apb3_state_e state_q, state_d;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic cmd_hs;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_hit;
  logic access_done;

  // cmd_ready_q (not the state) gates the handshake so nothing is accepted
  // in the cycle right after reset, when cmd_ready is still low.
  assign cmd_hs      = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;
  assign tmo_clr     = cmd_hs;
  assign tmo_en      = (state_q == ACCESS) && !bus.io_apb_PREADY;
  assign access_done = bus.io_apb_PREADY || tmo_hit;

  apb3_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk_i (io_apb_PCLK),
    .rst_ni(io_apb_PRESETn),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .hit_o (tmo_hit)
  );

  always_ff @(posedge io_apb_PCLK) begin
    if (!io_apb_PRESETn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_hs) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (access_done) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so every port is a flop.
  always_comb begin
    psel_d        = (state_d == SETUP) || (state_d == ACCESS);
    penable_d     = (state_d == ACCESS);
    cmd_ready_d   = (state_d == IDLE);
    rsp_valid_d   = (state_d == RESP);
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;

    if (cmd_hs) begin
      pwrite_d = bus.cmd_write;
      paddr_d  = bus.cmd_addr;
      pwdata_d = bus.cmd_wdata;
    end

    if (state_q == ACCESS) begin
      if (bus.io_apb_PREADY) begin
        rsp_rdata_d   = pwrite_q ? '0 : bus.io_apb_PRDATA;
        rsp_error_d   = bus.io_apb_PSLVERROR;
        rsp_timeout_d = 1'b0;
      end else if (tmo_hit) begin
        rsp_rdata_d   = '0;
        rsp_error_d   = 1'b1;
        rsp_timeout_d = 1'b1;
      end
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_error      = rsp_error_q;
  assign bus.rsp_timeout    = rsp_timeout_q;
  assign bus.io_apb_PADDR   = paddr_q;
  assign bus.io_apb_PSEL    = psel_q;
  assign bus.io_apb_PENABLE = penable_q;
  assign bus.io_apb_PWRITE  = pwrite_q;
  assign bus.io_apb_PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Self-checking bench for apb3_master_bridge: directed and random transfers
// against a cycle-count/response model derived from the transfer rules.
module tb_apb3_master_bridge;
  import apb3_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  apb3_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb3_master_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .io_apb_PCLK   (clk),
    .io_apb_PRESETn(rstn),
    .bus           (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_noise();
    bus.io_apb_PREADY    = 1'($urandom);
    bus.io_apb_PSLVERROR = 1'($urandom);
    bus.io_apb_PRDATA    = $urandom;
  endtask

  // One transfer entered from an IDLE negedge where cmd_ready is already high.
  // Model: ACCESS length = waits+1, or TO if the slave stalls TO cycles or more.
  task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int waits, input bit serr, input logic [DW-1:0] rd,
                        input int hold);
    bit              tmo;
    int              alen;
    int              guard;
    logic [DW-1:0]   exp_rd;
    bit              exp_err;
    tmo     = (TO != 0) && (waits >= int'(TO));
    alen    = tmo ? int'(TO) : waits + 1;
    exp_rd  = (tmo || wr) ? '0 : rd;
    exp_err = tmo ? 1'b1 : serr;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.rsp_ready = 1'b0;
    slave_noise();
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready_on_entry", 64'(guard), 64'(0));

    for (int c = 1; c <= alen + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = $urandom;
      end
      chk("psel", 64'(bus.io_apb_PSEL), 64'(1));
      chk("penable", 64'(bus.io_apb_PENABLE), 64'(c >= 2));
      chk("paddr", 64'(bus.io_apb_PADDR), 64'(a));
      chk("pwrite", 64'(bus.io_apb_PWRITE), 64'(wr));
      chk("pwdata", 64'(bus.io_apb_PWDATA), 64'(wd));
      chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
      chk("rsp_valid_early", 64'(bus.rsp_valid), 64'(0));
      if (c == 1) begin
        slave_noise();
      end else if (!tmo && (c - 2 == waits)) begin
        bus.io_apb_PREADY    = 1'b1;
        bus.io_apb_PSLVERROR = serr;
        bus.io_apb_PRDATA    = rd;
      end else begin
        bus.io_apb_PREADY    = 1'b0;
        bus.io_apb_PSLVERROR = 1'($urandom);
        bus.io_apb_PRDATA    = $urandom;
      end
    end

    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk("resp_psel", 64'(bus.io_apb_PSEL), 64'(0));
      chk("resp_penable", 64'(bus.io_apb_PENABLE), 64'(0));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("resp_cmd_ready", 64'(bus.cmd_ready), 64'(0));
      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
      chk("rsp_error", 64'(bus.rsp_error), 64'(exp_err));
      chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(tmo));
      slave_noise();
      bus.rsp_ready = (h == hold);
    end

    @(negedge clk);
    chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("idle_psel", 64'(bus.io_apb_PSEL), 64'(0));
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.io_apb_PREADY    = 1'b0;
    bus.io_apb_PSLVERROR = 1'b0;
    bus.io_apb_PRDATA    = '0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    chk("rst_psel", 64'(bus.io_apb_PSEL), 64'(0));
    chk("rst_penable", 64'(bus.io_apb_PENABLE), 64'(0));
    chk("rst_pwrite", 64'(bus.io_apb_PWRITE), 64'(0));
    chk("rst_paddr", 64'(bus.io_apb_PADDR), 64'(0));
    chk("rst_pwdata", 64'(bus.io_apb_PWDATA), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk("rst_rsp_error", 64'(bus.rsp_error), 64'(0));
    chk("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'(0));
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));

    // Directed cases: zero-wait write, 3-wait read (ties with the timeout),
    // slave error, timeout, long response back-pressure.
    do_txn(1'b1, 16'h1004, 32'hDEADBEEF, 0, 1'b0, 32'h12345678, 0);
    do_txn(1'b0, 16'h0008, 32'h00000000, 3, 1'b0, 32'h0000A5A5, 0);
    do_txn(1'b0, 16'h0010, 32'h00000000, 1, 1'b1, 32'hCAFEF00D, 0);
    do_txn(1'b0, 16'h0020, 32'h00000000, 10, 1'b0, 32'h11111111, 0);
    do_txn(1'b1, 16'h0030, 32'h55AA55AA, TO, 1'b0, 32'h0, 1);
    do_txn(1'b1, 16'h0040, 32'h01020304, 2, 1'b0, 32'h0, 5);

    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 7)),
             1'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of ACCESS aborts the transfer with no response.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 16'h0abc;
    bus.cmd_wdata = '0;
    bus.io_apb_PREADY = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("abort_in_access", 64'({bus.io_apb_PSEL, bus.io_apb_PENABLE}), 64'(3));
    rstn = 1'b0;
    bus.io_apb_PREADY = 1'b1;
    @(negedge clk);
    chk("abort_psel", 64'(bus.io_apb_PSEL), 64'(0));
    chk("abort_penable", 64'(bus.io_apb_PENABLE), 64'(0));
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_release_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(bus.rsp_valid), 64'(0));
      chk("abort_idle_psel", 64'(bus.io_apb_PSEL), 64'(0));
    end

    do_txn(1'b0, 16'h0ffc, 32'h0, 0, 1'b0, 32'h89ABCDEF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
